// File: rtl/ins_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ins_buffer_pkg
// Description : Shared sizes and types for the collapsing instruction buffer
//               (allocator and issue-select sides).
// Revision    : 1.0 - initial release
// ============================================================================
package ins_buffer_pkg;

  localparam int INS_BUF_DEPTH = 16;
  localparam int INS_LANES     = 4;

  typedef logic [3:0] ins_ptr_t;
  typedef logic [4:0] ins_addr_t;

  localparam ins_addr_t INS_NULL_ADDR = 5'd31;

endpackage
`default_nettype wire

// File: rtl/ins_pick_first.sv
`default_nettype none
// ============================================================================
// Module      : ins_pick_first
// Description : Finds the lowest set bit of a mask and returns the mask with
//               that bit removed, so instances can be chained per lane.
// Revision    : 1.0 - initial release
// ============================================================================
module ins_pick_first
  import ins_buffer_pkg::*;
#(
  parameter int DEPTH = INS_BUF_DEPTH
) (
  input  logic [DEPTH-1:0] mask_in,
  output logic             found,
  output ins_ptr_t         idx,
  output logic [DEPTH-1:0] mask_out
);

  // Scan downward so the last hit written is the lowest (oldest) slot
  always_comb begin
    found    = 1'b0;
    idx      = '0;
    mask_out = mask_in;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (mask_in[i]) begin
        found = 1'b1;
        idx   = ins_ptr_t'(i);
      end
    end
    if (found) begin
      mask_out[idx] = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/buffer_ins_issue_select.sv
`default_nettype none
// ============================================================================
// Module      : buffer_ins_issue_select
// Description : Picks up to four oldest ready entries of the 16-entry
//               collapsing queue, drives removal strobes, registers the picks
//               for the FU read pipeline and tracks occupancy / errors.
// Revision    : 1.0 - initial release
// ============================================================================
module buffer_ins_issue_select
  import ins_buffer_pkg::*;
#(
  parameter int        DEPTH     = INS_BUF_DEPTH,
  parameter int        LANES     = INS_LANES,
  parameter ins_addr_t NULL_ADDR = INS_NULL_ADDR
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DEPTH-1:0] entry_rdy,
  input  logic [2:0]       alloc_cnt,
  input  logic             fu_stall,
  output logic             ins_out_1,
  output logic             ins_out_2,
  output logic             ins_out_3,
  output logic             ins_out_4,
  output logic [4:0]       ins_out_1_addr,
  output logic [4:0]       ins_out_2_addr,
  output logic [4:0]       ins_out_3_addr,
  output logic [4:0]       ins_out_4_addr,
  output logic             iss_vld_1,
  output logic             iss_vld_2,
  output logic             iss_vld_3,
  output logic             iss_vld_4,
  output logic [4:0]       iss_addr_1,
  output logic [4:0]       iss_addr_2,
  output logic [4:0]       iss_addr_3,
  output logic [4:0]       iss_addr_4,
  output logic [4:0]       occupancy,
  output logic [4:0]       free_slots,
  output logic             ovf_err,
  output logic             udf_err
);

  localparam logic [5:0] c_full6 = 6'(DEPTH);
  localparam logic [4:0] c_full5 = 5'(DEPTH);

  logic [4:0]       r_occ;
  logic             r_ovf;
  logic             r_udf;
  logic [LANES-1:0] r_iss_vld;
  ins_addr_t        r_iss_addr [LANES];

  logic [DEPTH-1:0] w_elig;
  logic [DEPTH-1:0] w_mask [LANES+1];
  logic [DEPTH-1:0] w_picked;
  logic [LANES-1:0] w_found;
  ins_ptr_t         w_idx  [LANES];
  ins_addr_t        w_addr [LANES];
  logic [2:0]       w_issued;
  logic [5:0]       w_sum;
  logic             w_udf;
  logic             w_ovf;
  logic [4:0]       w_occ_nxt;

  // Only slots holding a valid instruction may be picked, and none while stalled
  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_elig
      assign w_elig[i] = entry_rdy[i] & (r_occ > 5'(i)) & ~fu_stall;
    end
  endgenerate

  assign w_mask[0] = w_elig;

  // Each lane takes the oldest slot the previous lanes left behind,
  // which keeps the filled lanes contiguous from lane 1
  generate
    for (genvar k = 0; k < LANES; k++) begin : g_lane
      ins_pick_first #(.DEPTH(DEPTH)) u_pick (
        .mask_in  (w_mask[k]),
        .found    (w_found[k]),
        .idx      (w_idx[k]),
        .mask_out (w_mask[k+1])
      );
      assign w_addr[k] = w_found[k] ? {1'b0, w_idx[k]} : NULL_ADDR;
    end
  endgenerate

  // Slots cleared by the cascade are exactly the issued ones (at most LANES)
  assign w_picked = w_elig & ~w_mask[LANES];
  assign w_issued = 3'($countones(w_picked));

  // Issue and allocate are folded into one net occupancy update
  always_comb begin
    w_sum     = {1'b0, r_occ} - {3'b000, w_issued} + {3'b000, alloc_cnt};
    w_udf     = ({2'b00, w_issued} > r_occ);
    w_ovf     = (alloc_cnt > 3'd4) | (~w_udf & (w_sum > c_full6));
    w_occ_nxt = w_sum[4:0];
    if (w_ovf) begin
      w_occ_nxt = c_full5;
    end else if (w_udf) begin
      w_occ_nxt = {2'b00, alloc_cnt};
    end
  end

  // Occupancy, sticky error flags and the registered issue stage
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_occ     <= '0;
      r_ovf     <= 1'b0;
      r_udf     <= 1'b0;
      r_iss_vld <= '0;
      for (int k = 0; k < LANES; k++) begin
        r_iss_addr[k] <= NULL_ADDR;
      end
    end else begin
      r_occ     <= w_occ_nxt;
      r_ovf     <= r_ovf | w_ovf;
      r_udf     <= r_udf | w_udf;
      r_iss_vld <= w_found;
      for (int k = 0; k < LANES; k++) begin
        r_iss_addr[k] <= w_addr[k];
      end
    end
  end

  assign ins_out_1      = w_found[0];
  assign ins_out_2      = w_found[1];
  assign ins_out_3      = w_found[2];
  assign ins_out_4      = w_found[3];
  assign ins_out_1_addr = w_addr[0];
  assign ins_out_2_addr = w_addr[1];
  assign ins_out_3_addr = w_addr[2];
  assign ins_out_4_addr = w_addr[3];

  assign iss_vld_1  = r_iss_vld[0];
  assign iss_vld_2  = r_iss_vld[1];
  assign iss_vld_3  = r_iss_vld[2];
  assign iss_vld_4  = r_iss_vld[3];
  assign iss_addr_1 = r_iss_addr[0];
  assign iss_addr_2 = r_iss_addr[1];
  assign iss_addr_3 = r_iss_addr[2];
  assign iss_addr_4 = r_iss_addr[3];

  assign occupancy  = r_occ;
  assign free_slots = c_full5 - r_occ;
  assign ovf_err    = r_ovf;
  assign udf_err    = r_udf;

endmodule
`default_nettype wire

// File: tb/tb_buffer_ins_issue_select.sv
`default_nettype none
// ============================================================================
// Module      : tb_buffer_ins_issue_select
// Description : Directed scoreboard bench for buffer_ins_issue_select.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_buffer_ins_issue_select;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] entry_rdy;
  logic [2:0]  alloc_cnt;
  logic        fu_stall;
  logic        ins_out_1, ins_out_2, ins_out_3, ins_out_4;
  logic [4:0]  ins_out_1_addr, ins_out_2_addr, ins_out_3_addr, ins_out_4_addr;
  logic        iss_vld_1, iss_vld_2, iss_vld_3, iss_vld_4;
  logic [4:0]  iss_addr_1, iss_addr_2, iss_addr_3, iss_addr_4;
  logic [4:0]  occupancy, free_slots;
  logic        ovf_err, udf_err;

  localparam logic [4:0] N = 5'd31;

  buffer_ins_issue_select dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .entry_rdy      (entry_rdy),
    .alloc_cnt      (alloc_cnt),
    .fu_stall       (fu_stall),
    .ins_out_1      (ins_out_1),
    .ins_out_2      (ins_out_2),
    .ins_out_3      (ins_out_3),
    .ins_out_4      (ins_out_4),
    .ins_out_1_addr (ins_out_1_addr),
    .ins_out_2_addr (ins_out_2_addr),
    .ins_out_3_addr (ins_out_3_addr),
    .ins_out_4_addr (ins_out_4_addr),
    .iss_vld_1      (iss_vld_1),
    .iss_vld_2      (iss_vld_2),
    .iss_vld_3      (iss_vld_3),
    .iss_vld_4      (iss_vld_4),
    .iss_addr_1     (iss_addr_1),
    .iss_addr_2     (iss_addr_2),
    .iss_addr_3     (iss_addr_3),
    .iss_addr_4     (iss_addr_4),
    .occupancy      (occupancy),
    .free_slots     (free_slots),
    .ovf_err        (ovf_err),
    .udf_err        (udf_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    int          kind;
    logic [19:0] exp;
    string       name;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [19:0] actual(input int kind);
    case (kind)
      0: return {16'd0, ins_out_4, ins_out_3, ins_out_2, ins_out_1};
      1: return {ins_out_4_addr, ins_out_3_addr, ins_out_2_addr, ins_out_1_addr};
      2: return {16'd0, iss_vld_4, iss_vld_3, iss_vld_2, iss_vld_1};
      3: return {iss_addr_4, iss_addr_3, iss_addr_2, iss_addr_1};
      4: return {15'd0, occupancy};
      5: return {15'd0, free_slots};
      6: return {19'd0, ovf_err};
      default: return {19'd0, udf_err};
    endcase
  endfunction

  task automatic push(input int c, input int kind, input logic [19:0] e, input string n);
    exp_t x;
    x.cyc  = c;
    x.kind = kind;
    x.exp  = e;
    x.name = n;
    q.push_back(x);
  endtask

  // Monitor: compare every expectation due in the current cycle
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t x;
      logic [19:0] a;
      x = q.pop_front();
      checks++;
      if (x.cyc < cyc) begin
        errors++;
        $display("FAIL %s: stale expectation, due cycle %0d seen at %0d", x.name, x.cyc, cyc);
      end else begin
        a = actual(x.kind);
        if (a !== x.exp) begin
          errors++;
          $display("FAIL %s: got %0h required %0h", x.name, a, x.exp);
        end
      end
    end
  end

  // Drive one cycle and queue its same-cycle and next-cycle expectations
  task automatic step(input logic rs, input logic [15:0] rdy, input logic [2:0] al,
                      input logic st, input logic [3:0] es,
                      input logic [4:0] a1, input logic [4:0] a2,
                      input logic [4:0] a3, input logic [4:0] a4,
                      input logic [4:0] occn, input logic ovfn, input string nm);
    rst_n     = rs;
    entry_rdy = rdy;
    alloc_cnt = al;
    fu_stall  = st;
    push(cyc,     0, {16'd0, es},              {nm, ".strb"});
    push(cyc,     1, {a4, a3, a2, a1},         {nm, ".addr"});
    push(cyc + 1, 2, rs ? {16'd0, es} : 20'd0, {nm, ".iss_vld"});
    push(cyc + 1, 3, rs ? {a4, a3, a2, a1} : 20'hFFFFF, {nm, ".iss_addr"});
    push(cyc + 1, 4, {15'd0, occn},            {nm, ".occ"});
    push(cyc + 1, 5, {15'd0, 5'd16 - occn},    {nm, ".free"});
    push(cyc + 1, 6, {19'd0, ovfn},            {nm, ".ovf"});
    push(cyc + 1, 7, 20'd0,                    {nm, ".udf"});
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    entry_rdy = '0;
    alloc_cnt = '0;
    fu_stall  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    //    rst   rdy       al  st  strb  a1  a2  a3  a4  occ  ovf
    step(1'b0, 16'h0000, 4, 0, 4'h0, N,  N,  N,  N,  0,   0, "rst");
    step(1'b1, 16'h0000, 4, 0, 4'h0, N,  N,  N,  N,  4,   0, "fill1");
    step(1'b1, 16'h0000, 4, 0, 4'h0, N,  N,  N,  N,  8,   0, "fill2");
    step(1'b1, 16'h0000, 4, 0, 4'h0, N,  N,  N,  N,  12,  0, "fill3");
    step(1'b1, 16'h0000, 4, 0, 4'h0, N,  N,  N,  N,  16,  0, "fill4");
    step(1'b1, 16'hFFFF, 0, 0, 4'hF, 0,  1,  2,  3,  12,  0, "full_issue");
    step(1'b1, 16'h0003, 0, 0, 4'h3, 0,  1,  N,  N,  10,  0, "two");
    step(1'b1, 16'h4222, 0, 0, 4'h7, 1,  5,  9,  N,  7,   0, "sparse");
    step(1'b1, 16'h0000, 1, 0, 4'h0, N,  N,  N,  N,  8,   0, "alloc1");
    step(1'b1, 16'hFFFF, 2, 1, 4'h0, N,  N,  N,  N,  10,  0, "stall");
    step(1'b1, 16'h0000, 4, 0, 4'h0, N,  N,  N,  N,  14,  0, "to14");
    step(1'b1, 16'h2084, 4, 0, 4'h7, 2,  7,  13, N,  15,  0, "iss_alloc");
    step(1'b1, 16'h0000, 2, 0, 4'h0, N,  N,  N,  N,  16,  1, "ovf");
    step(1'b1, 16'h8000, 0, 0, 4'h1, 15, N,  N,  N,  15,  1, "top_slot");
    step(1'b1, 16'h003F, 0, 0, 4'hF, 0,  1,  2,  3,  11,  1, "four");
    step(1'b1, 16'h0003, 0, 0, 4'h3, 0,  1,  N,  N,  9,   1, "to9");
    step(1'b0, 16'h0000, 4, 0, 4'h0, N,  N,  N,  N,  0,   0, "mid_rst");
    step(1'b1, 16'hFFFF, 0, 0, 4'h0, N,  N,  N,  N,  0,   0, "empty");
    step(1'b1, 16'h0000, 7, 0, 4'h0, N,  N,  N,  N,  16,  1, "alloc_bad");
    step(1'b0, 16'h0000, 0, 0, 4'h0, N,  N,  N,  N,  0,   0, "rst2");
    for (int k = 0; k < 5 && q.size() > 0; k++) @(posedge clk);
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/buffer_ins_issue_select.md
# buffer_ins_issue_select

Read-side companion to the instruction buffer's allocation logic. It tracks occupancy of the 16-entry collapsing instruction queue, selects up to four of the oldest ready entries per cycle, and drives the per-lane removal strobes that the allocator consumes to compact the queue. It also registers the selected addresses for the functional-unit read pipeline and reports free space upstream.

## Interface
- `DEPTH`, 16: queue entries; the pointer is 4 bits and the address is 5 bits.
- `LANES`, 4: issue lanes, fixed at 4.
- `NULL_ADDR`, 31: address driven on an invalid lane.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  synchronous active-low reset.
- `entry_rdy`  in  16  per-entry operands-ready; bit i is queue slot i, and slot 0 is the oldest.
- `alloc_cnt`  in  3  number of instructions allocated this cycle, 0..4 (the allocator's valid sum).
- `fu_stall`  in  1  downstream backpressure; no issue this cycle when high.
- `ins_out_1`..`ins_out_4`  out  1 each  combinational removal strobes to the allocator, lane-ordered.
- `ins_out_1_addr`..`ins_out_4_addr`  out  5 each  combinational selected slot, `NULL_ADDR` when the lane is idle.
- `iss_vld_1`..`iss_vld_4`  out  1 each  registered copy of `ins_out_k`.
- `iss_addr_1`..`iss_addr_4`  out  5 each  registered copy of `ins_out_k_addr`.
- `occupancy`  out  5  registered entry count, 0..16.
- `free_slots`  out  5  `16 - occupancy`, combinational from the register.
- `ovf_err`  out  1  sticky overflow flag.
- `udf_err`  out  1  sticky underflow flag.

## Operation
- Eligible mask: `elig[i] = entry_rdy[i] & (i < occupancy) & ~fu_stall`.
- Selection: a priority scan from slot 0 upward. Lane 1 takes the lowest eligible slot, lane 2 the next, and so on up to 4 picks. Lanes are filled contiguously from lane 1, with no gaps.
- Unfilled lanes: `ins_out_k = 0` and address `NULL_ADDR`.
- `issued = ins_out_1 + .. + ins_out_4`, 3-bit, range 0..4.
- Occupancy next, computed at 6 bits: `occ - issued + alloc_cnt`.
  - If the result exceeds 16: set `ovf_err` and clamp occupancy to 16.
  - `alloc_cnt > 4`: treated as overflow, same response.
  - Issue cannot exceed occupancy by construction. `udf_err` is a defensive check and sets if `issued > occupancy`.
- Simultaneous issue and allocate in one cycle is legal. The net change is applied in a single update.
- Error flags stay set until reset. Operation continues with clamped occupancy.
- The block does not re-select an issued entry. Removal and compaction take effect at the same clock edge in the buffer, so next cycle's `entry_rdy` already reflects the shifted queue.

## Timing
- Strobes `ins_out_*` and their addresses are combinational from `entry_rdy`, `occupancy` and `fu_stall`, valid in the same cycle.
- `iss_vld_*` and `iss_addr_*` lag the strobes by exactly one cycle. A stall produces an idle registered cycle (all valids 0).
- `occupancy` updates on the edge following strobe and `alloc_cnt`.
- Reset (`rst_n = 0` sampled at an edge):
  - `occupancy = 0`, `iss_vld_* = 0`, `iss_addr_* = 31`, `ovf_err = udf_err = 0`.
  - With occupancy 0, the strobes are 0 and addresses 31 during and after reset.
- Reset mid-operation discards all state; `alloc_cnt` in the reset cycle is ignored.
- Empty queue (occupancy 0): no issue, regardless of `entry_rdy`.
- Full queue (occupancy 16): `free_slots = 0`.
- Ready bits at or above `occupancy` are ignored.

## Structure
- Shared package `ins_buffer_pkg`:
  - `INS_BUF_DEPTH = 16`, `INS_LANES = 4`, `INS_NULL_ADDR = 5'd31`.
  - Typedefs `ins_ptr_t` (4-bit) and `ins_addr_t` (5-bit).
  - Used by both the allocator and this block.
- Sub-module `ins_pick_first`: given a 16-bit mask, returns the lowest set index and the mask with that bit cleared. Instantiate it four times in cascade.
- Top level holds the occupancy register, error flags and issue registers.

## Test plan
- Reset, then `alloc_cnt = 4` for 4 cycles with `entry_rdy = 0` -> occupancy 4, 8, 12, 16; `free_slots` 0; no strobes.
- Occupancy 16, `entry_rdy = 16'hFFFF` -> lanes 1–4 addresses 0, 1, 2, 3, all strobes high. Next cycle `iss_addr` = 0, 1, 2, 3 and occupancy 12.
- Occupancy 10, `entry_rdy` bits {1, 5, 9, 14} -> lanes 1–3 addresses 1, 5, 9; lane 4 strobe 0, address 31 (slot 14 is beyond occupancy). Occupancy becomes 7.
- Occupancy 8, all ready, `fu_stall = 1`, `alloc_cnt = 2` -> no strobes, all addresses 31; occupancy 10; next-cycle `iss_vld` all 0.
- Occupancy 14, three ready, `alloc_cnt = 4` -> issued 3, occupancy 15, no error. Then `alloc_cnt = 2` with none ready -> `ovf_err = 1`, occupancy clamped to 16.
- Assert `rst_n = 0` mid-stream at occupancy 9 -> next cycle occupancy 0, flags cleared, `iss_addr` all 31.
